// File: rtl/id_ex_alu_issue.sv
// ID/EX pipeline register for the 5-stage MIPS core. It also decodes the ALU
// operation code and extends the immediate, so EX receives ready-to-use operands.
module id_ex_alu_issue #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          flush,
  input  logic          id_valid,
  input  logic [1:0]    id_aluop,
  input  logic [5:0]    id_opcode,
  input  logic [5:0]    id_funct,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic [15:0]   id_imm,
  input  logic          id_alusrc,
  input  logic [RW-1:0] id_rt_addr,
  input  logic [RW-1:0] id_rd_addr,
  input  logic          id_regdst,
  input  logic          id_regwrite,
  input  logic          id_memread,
  input  logic          id_memwrite,
  input  logic          id_memtoreg,
  output logic          ex_valid,
  output logic [DW-1:0] ex_a,
  output logic [DW-1:0] ex_b,
  output logic [3:0]    ex_alu_ctrl,
  output logic [DW-1:0] ex_store_data,
  output logic [RW-1:0] ex_write_reg,
  output logic          ex_regwrite,
  output logic          ex_memread,
  output logic          ex_memwrite,
  output logic          ex_memtoreg,
  output logic          ex_illegal
);

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_NONE = 4'b1111;

  logic [3:0]    alu_ctrl_d;
  logic          zero_ext;
  logic [DW-1:0] imm_ext;
  logic          unsupported;
  logic          ctl_en;

  logic          valid_q;
  logic [DW-1:0] a_q, b_q, store_data_q;
  logic [3:0]    alu_ctrl_q;
  logic [RW-1:0] write_reg_q;
  logic          regwrite_q, memread_q, memwrite_q, memtoreg_q, illegal_q;

  always_comb begin
    alu_ctrl_d = ALU_NONE;
    unique case (id_aluop)
      2'b00: alu_ctrl_d = ALU_ADD;
      2'b01: alu_ctrl_d = ALU_SUB;
      2'b10: begin
        unique case (id_funct)
          6'h20, 6'h21: alu_ctrl_d = ALU_ADD;
          6'h22, 6'h23: alu_ctrl_d = ALU_SUB;
          6'h24:        alu_ctrl_d = ALU_AND;
          6'h25:        alu_ctrl_d = ALU_OR;
          6'h2A:        alu_ctrl_d = ALU_SLT;
          default:      alu_ctrl_d = ALU_NONE;
        endcase
      end
      default: begin
        unique case (id_opcode)
          6'h0C:   alu_ctrl_d = ALU_AND;
          6'h0D:   alu_ctrl_d = ALU_OR;
          6'h0A:   alu_ctrl_d = ALU_SLT;
          default: alu_ctrl_d = ALU_NONE;
        endcase
      end
    endcase
  end

  // Only andi/ori treat the immediate as unsigned; slti and address math sign-extend.
  assign zero_ext    = (id_aluop == 2'b11) && ((id_opcode == 6'h0C) || (id_opcode == 6'h0D));
  assign imm_ext     = zero_ext ? {{(DW-16){1'b0}}, id_imm} : {{(DW-16){id_imm[15]}}, id_imm};
  assign unsupported = (alu_ctrl_d == ALU_NONE);
  // Side-effecting controls need a real, decodable instruction.
  assign ctl_en      = id_valid && !unsupported;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      valid_q      <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      alu_ctrl_q   <= 4'b0000;
      store_data_q <= '0;
      write_reg_q  <= '0;
      regwrite_q   <= 1'b0;
      memread_q    <= 1'b0;
      memwrite_q   <= 1'b0;
      memtoreg_q   <= 1'b0;
      illegal_q    <= 1'b0;
    end else if (!stall) begin
      valid_q      <= id_valid;
      a_q          <= id_rs_data;
      b_q          <= id_alusrc ? imm_ext : id_rt_data;
      alu_ctrl_q   <= alu_ctrl_d;
      store_data_q <= id_rt_data;
      write_reg_q  <= id_regdst ? id_rd_addr : id_rt_addr;
      regwrite_q   <= ctl_en && id_regwrite;
      memread_q    <= ctl_en && id_memread;
      memwrite_q   <= ctl_en && id_memwrite;
      memtoreg_q   <= id_valid && id_memtoreg;
      illegal_q    <= id_valid && unsupported;
    end
  end

  assign ex_valid      = valid_q;
  assign ex_a          = a_q;
  assign ex_b          = b_q;
  assign ex_alu_ctrl   = alu_ctrl_q;
  assign ex_store_data = store_data_q;
  assign ex_write_reg  = write_reg_q;
  assign ex_regwrite   = regwrite_q;
  assign ex_memread    = memread_q;
  assign ex_memwrite   = memwrite_q;
  assign ex_memtoreg   = memtoreg_q;
  assign ex_illegal    = illegal_q;

endmodule

// File: tb/tb_id_ex_alu_issue.sv
// Directed plus randomized bench for id_ex_alu_issue; a table-driven reference
// model predicts the registered EX slot each cycle.
module tb_id_ex_alu_issue;

  logic        clk = 1'b0;
  logic        rst, stall, flush, id_valid;
  logic [1:0]  id_aluop;
  logic [5:0]  id_opcode, id_funct;
  logic [31:0] id_rs_data, id_rt_data;
  logic [15:0] id_imm;
  logic        id_alusrc, id_regdst;
  logic [4:0]  id_rt_addr, id_rd_addr;
  logic        id_regwrite, id_memread, id_memwrite, id_memtoreg;
  logic        ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_illegal;
  logic [31:0] ex_a, ex_b, ex_store_data;
  logic [3:0]  ex_alu_ctrl;
  logic [4:0]  ex_write_reg;

  typedef struct packed {
    logic        valid;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ctrl;
    logic [31:0] sd;
    logic [4:0]  wr;
    logic        rw, mr, mw, mt, ill;
  } slot_t;

  slot_t exp_slot;
  int vectors = 0;
  int miscompares = 0;
  int funct_map[int];
  int opcode_map[int];

  always #5 clk = ~clk;

  id_ex_alu_issue #(.DW(32), .RW(5)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_aluop(id_aluop), .id_opcode(id_opcode), .id_funct(id_funct),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_alusrc(id_alusrc), .id_rt_addr(id_rt_addr), .id_rd_addr(id_rd_addr),
    .id_regdst(id_regdst), .id_regwrite(id_regwrite), .id_memread(id_memread),
    .id_memwrite(id_memwrite), .id_memtoreg(id_memtoreg),
    .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b), .ex_alu_ctrl(ex_alu_ctrl),
    .ex_store_data(ex_store_data), .ex_write_reg(ex_write_reg),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
    .ex_memtoreg(ex_memtoreg), .ex_illegal(ex_illegal)
  );

  // Reference: what the EX slot should hold after loading the current ID inputs.
  function automatic slot_t predict_load();
    slot_t s;
    int code;
    int imm_val;
    bit bad;
    if (id_aluop == 2'd0)      code = 2;
    else if (id_aluop == 2'd1) code = 6;
    else if (id_aluop == 2'd2) code = funct_map.exists(int'(id_funct)) ? funct_map[int'(id_funct)] : 15;
    else                       code = opcode_map.exists(int'(id_opcode)) ? opcode_map[int'(id_opcode)] : 15;
    bad = (code == 15);
    imm_val = int'(id_imm);
    if (!(id_aluop == 2'd3 && (id_opcode == 6'd12 || id_opcode == 6'd13)) && imm_val >= 32768)
      imm_val = imm_val - 65536;
    s.valid = id_valid;
    s.a     = id_rs_data;
    s.b     = id_alusrc ? 32'(imm_val) : id_rt_data;
    s.ctrl  = 4'(code);
    s.sd    = id_rt_data;
    s.wr    = id_regdst ? id_rd_addr : id_rt_addr;
    s.rw    = id_valid && !bad && id_regwrite;
    s.mr    = id_valid && !bad && id_memread;
    s.mw    = id_valid && !bad && id_memwrite;
    s.mt    = id_valid && id_memtoreg;
    s.ill   = id_valid && bad;
    return s;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst || flush) exp_slot = '0;
    else if (!stall)  exp_slot = predict_load();
    #1;
    chk("valid", 32'(ex_valid), 32'(exp_slot.valid));
    chk("a", ex_a, exp_slot.a);
    chk("b", ex_b, exp_slot.b);
    chk("alu_ctrl", 32'(ex_alu_ctrl), 32'(exp_slot.ctrl));
    chk("store_data", ex_store_data, exp_slot.sd);
    chk("write_reg", 32'(ex_write_reg), 32'(exp_slot.wr));
    chk("regwrite", 32'(ex_regwrite), 32'(exp_slot.rw));
    chk("memread", 32'(ex_memread), 32'(exp_slot.mr));
    chk("memwrite", 32'(ex_memwrite), 32'(exp_slot.mw));
    chk("memtoreg", 32'(ex_memtoreg), 32'(exp_slot.mt));
    chk("illegal", 32'(ex_illegal), 32'(exp_slot.ill));
  endtask

  task automatic rand_inputs();
    int pick;
    logic [5:0] legal_f[7] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h2A};
    logic [5:0] legal_o[3] = '{6'h0C, 6'h0D, 6'h0A};
    id_valid    = ($urandom_range(0, 9) != 0);
    id_aluop    = 2'($urandom_range(0, 3));
    pick        = $urandom_range(0, 9);
    id_funct    = (pick < 7) ? legal_f[pick] : 6'($urandom);
    pick        = $urandom_range(0, 5);
    id_opcode   = (pick < 3) ? legal_o[pick] : 6'($urandom);
    id_rs_data  = $urandom;
    id_rt_data  = $urandom;
    id_imm      = 16'($urandom);
    id_alusrc   = 1'($urandom);
    id_rt_addr  = 5'($urandom);
    id_rd_addr  = 5'($urandom);
    id_regdst   = 1'($urandom);
    id_regwrite = 1'($urandom);
    id_memread  = 1'($urandom);
    id_memwrite = 1'($urandom);
    id_memtoreg = 1'($urandom);
  endtask

  task automatic set_op(input logic [1:0] aluop, input logic [5:0] opc, input logic [5:0] fn);
    id_valid = 1'b1; id_aluop = aluop; id_opcode = opc; id_funct = fn;
  endtask

  initial begin
    funct_map[32] = 2; funct_map[33] = 2; funct_map[34] = 6; funct_map[35] = 6;
    funct_map[36] = 0; funct_map[37] = 1; funct_map[42] = 7;
    opcode_map[12] = 0; opcode_map[13] = 1; opcode_map[10] = 7;
    exp_slot = '0;
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    rand_inputs();
    @(negedge clk);

    // Reset: two cycles with arbitrary inputs, everything zero.
    for (int i = 0; i < 2; i++) begin
      rand_inputs();
      tick();
      chk("rst_valid", 32'(ex_valid), 32'd0);
      chk("rst_ctrl", 32'(ex_alu_ctrl), 32'd0);
    end
    rst = 1'b0;

    // R-type add: first load after reset release.
    rand_inputs();
    set_op(2'b10, 6'h00, 6'h20);
    id_rs_data = 32'd5; id_rt_data = 32'd7; id_alusrc = 1'b0;
    id_regdst = 1'b1; id_rd_addr = 5'd3; id_regwrite = 1'b1;
    tick();
    chk("radd_ctrl", 32'(ex_alu_ctrl), 32'h2);
    chk("radd_b", ex_b, 32'd7);
    chk("radd_wr", 32'(ex_write_reg), 32'd3);

    // Immediate extension: addi sign-extends, ori zero-extends.
    set_op(2'b00, 6'h08, 6'h00); id_imm = 16'hFFFF; id_alusrc = 1'b1;
    tick();
    chk("addi_b", ex_b, 32'hFFFF_FFFF);
    set_op(2'b11, 6'h0D, 6'h00); id_imm = 16'hFFFF; id_alusrc = 1'b1;
    tick();
    chk("ori_b", ex_b, 32'h0000_FFFF);
    chk("ori_ctrl", 32'(ex_alu_ctrl), 32'h1);

    // Load sub, hold it through a 3-cycle stall, then flush beats stall.
    rand_inputs();
    set_op(2'b10, 6'h00, 6'h22); id_regwrite = 1'b1;
    tick();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_inputs();
      tick();
      chk("stall_ctrl", 32'(ex_alu_ctrl), 32'h6);
      chk("stall_valid", 32'(ex_valid), 32'd1);
    end
    flush = 1'b1;
    tick();
    chk("flush_valid", 32'(ex_valid), 32'd0);
    stall = 1'b0; flush = 1'b0;

    // Unsupported funct.
    rand_inputs();
    set_op(2'b10, 6'h00, 6'h18); id_regwrite = 1'b1; id_memwrite = 1'b1;
    tick();
    chk("ill_ctrl", 32'(ex_alu_ctrl), 32'hF);
    chk("ill_flag", 32'(ex_illegal), 32'd1);

    // Bubble input, then four back-to-back instructions.
    rand_inputs();
    set_op(2'b00, 6'h00, 6'h20); id_valid = 1'b0; id_regwrite = 1'b1;
    tick();
    chk("bubble_rw", 32'(ex_regwrite), 32'd0);
    set_op(2'b10, 6'h00, 6'h2A); tick(); chk("seq_slt", 32'(ex_alu_ctrl), 32'h7);
    set_op(2'b10, 6'h00, 6'h24); tick(); chk("seq_and", 32'(ex_alu_ctrl), 32'h0);
    set_op(2'b10, 6'h00, 6'h25); tick(); chk("seq_or", 32'(ex_alu_ctrl), 32'h1);
    set_op(2'b00, 6'h23, 6'h00); id_memread = 1'b1; tick();
    chk("seq_lw", 32'(ex_alu_ctrl), 32'h2);
    chk("seq_lw_valid", 32'(ex_valid), 32'd1);

    // Randomized traffic with occasional reset, flush and stall.
    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      rst   = ($urandom_range(0, 39) == 0);
      flush = ($urandom_range(0, 14) == 0);
      stall = ($urandom_range(0, 4) == 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/id_ex_alu_issue.md
Name: id_ex_alu_issue

Overview:
- ID/EX pipeline register and ALU-control issuer for the 5-stage MIPS core.
- Takes the decoded instruction fields and register-file operands from ID.
- Produces the registered operand pair and 4-bit ALU operation code that the EX-stage ALU consumes.
- Provides the stall (hold) and flush (bubble) semantics the hazard unit requires.

Parameters:
- DW, 32, datapath width for operands and immediate extension.
- RW, 5, register-address width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hold ID/EX contents.
- flush  in  1  insert bubble into EX.
- id_valid  in  1  ID holds a real instruction.
- id_aluop  in  2  00 add, 01 sub, 10 R-type (use funct), 11 immediate-logical (use opcode).
- id_opcode  in  6  instruction opcode.
- id_funct  in  6  instruction funct field.
- id_rs_data  in  DW  register rs value.
- id_rt_data  in  DW  register rt value.
- id_imm  in  16  instruction immediate.
- id_alusrc  in  1  1 = operand B is the extended immediate.
- id_rt_addr  in  RW  rt field.
- id_rd_addr  in  RW  rd field.
- id_regdst  in  1  1 = destination is rd, 0 = rt.
- id_regwrite, id_memread, id_memwrite, id_memtoreg  in  1 each  control bits.
- ex_valid  out  1  EX slot holds a real instruction.
- ex_a  out  DW  ALU operand a (rs value).
- ex_b  out  DW  ALU operand b (rt value or extended immediate).
- ex_alu_ctrl  out  4  ALU operation code.
- ex_store_data  out  DW  rt value for stores.
- ex_write_reg  out  RW  destination register.
- ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg  out  1 each  registered control bits.
- ex_illegal  out  1  unsupported R-type funct or aluop-11 opcode.

Behaviour:
- All outputs are registered; latency is exactly 1 cycle from ID inputs to ex_* outputs.
- Update priority per rising edge: rst > flush > stall > load.
- rst: every output is 0. ex_alu_ctrl resets to 4'b0000.
- flush: same values as rst. Flush wins over a simultaneous stall.
- stall (no flush): every output holds its previous value.
- load: all ex_* outputs are captured from the id_* inputs. ex_valid takes id_valid.
  - If id_valid=0, all control bits are forced to 0 and ex_illegal to 0.
- ALU op codes: 0010 add, 0110 sub, 0000 and, 0001 or, 0111 set-less-than, 1111 none.
- aluop 00 -> 0010. aluop 01 -> 0110.
- aluop 10 by funct:
  - 0x20 and 0x21 -> 0010.
  - 0x22 and 0x23 -> 0110.
  - 0x24 -> 0000. 0x25 -> 0001. 0x2A -> 0111.
  - Any other funct -> 1111.
- aluop 11 by opcode:
  - 0x0C (andi) -> 0000.
  - 0x0D (ori) -> 0001.
  - 0x0A (slti) -> 0111.
  - Any other opcode -> 1111.
- Code 1111 sets ex_illegal=1 and forces ex_regwrite, ex_memread and ex_memwrite to 0. ex_valid still follows id_valid.
- Immediate extension: zero-extend id_imm when aluop=11 and opcode is 0x0C or 0x0D. Sign-extend id_imm in all other cases.
- ex_b = extended immediate when id_alusrc=1, else id_rt_data. ex_store_data = id_rt_data always.
- ex_write_reg = id_rd_addr when id_regdst=1, else id_rt_addr.
- The ALU result zero flag is not handled here; branch resolution belongs to EX.
- Back-to-back loads with no stall issue one instruction per cycle with no bubbles.

Test Plan:
- Reset: assert rst for 2 cycles with arbitrary inputs -> every output 0. The cycle after release loads normally.
- R-type add: aluop=10, funct=0x20, rs=5, rt=7, alusrc=0, regdst=1, rd=3, regwrite=1 -> next cycle ex_alu_ctrl=0010, ex_a=5, ex_b=7, ex_write_reg=3, ex_regwrite=1, ex_valid=1.
- Extension:
  - addi imm=0xFFFF (aluop=00, alusrc=1) -> ex_b=0xFFFFFFFF, ex_alu_ctrl=0010.
  - ori imm=0xFFFF (aluop=11, opcode=0x0D) -> ex_b=0x0000FFFF, ex_alu_ctrl=0001.
- Stall/flush: load sub (funct=0x22), then hold stall=1 for 3 cycles with new inputs -> outputs unchanged. Assert stall=1 and flush=1 together -> ex_valid=0, all controls 0.
- Illegal: aluop=10, funct=0x18, regwrite=1, memwrite=1 -> ex_alu_ctrl=1111, ex_illegal=1, ex_regwrite=0, ex_memwrite=0.
- Bubble input and throughput: id_valid=0 with regwrite=1 -> ex_valid=0, ex_regwrite=0. Then 4 consecutive valid slt/and/or/lw -> codes 0111, 0000, 0001, 0010 on consecutive cycles.
